atpg_vector_sequencer: RTL



---
 rtl/atpg_pkg.sv | 30 +++
 rtl/atpg_vec_mem.sv | 27 ++
 rtl/atpg_vector_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/atpg_pkg.sv
// Shared types and helpers for the ATPG vector sequencer: FSM states,
// default MISR polynomial and the MISR step used by RTL and golden model.
package atpg_pkg;

   localparam int unsigned MISR_MAX_W = 64;
   localparam int unsigned MISR_IW    = 6;
   localparam logic [31:0] MISR_POLY_DEFAULT = 32'h04C11DB7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   // One MISR shift of a w-bit register held in the low bits; caller truncates to w.
   function automatic logic [MISR_MAX_W-1:0] misr_step(
      input logic [MISR_MAX_W-1:0] sig,
      input logic [MISR_MAX_W-1:0] data,
      input logic [MISR_MAX_W-1:0] poly,
      input int unsigned           w
   );
      logic [MISR_MAX_W-1:0] nxt;
      nxt = sig << 1;
      if (sig[MISR_IW'(w - 1)]) nxt = nxt ^ poly;
      return nxt ^ data;
   endfunction

endpackage

// File: rtl/atpg_vec_mem.sv
// Vector memory: DEPTH entries of {stimulus, expected}, one synchronous
// write port and one asynchronous read port. No reset; contents persist.
module atpg_vec_mem #(
   parameter  int unsigned DEPTH = 16,
   parameter  int unsigned IN_W  = 41,
   parameter  int unsigned OUT_W = 32,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [IN_W-1:0]  wstim,
   input  logic [OUT_W-1:0] wexp,
   input  logic [AW-1:0]    raddr,
   output logic [IN_W-1:0]  rstim_c,
   output logic [OUT_W-1:0] rexp_c
);

   logic [IN_W+OUT_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= {wstim, wexp};
   end

   assign {rstim_c, rexp_c} = mem[raddr];

endmodule

// File: rtl/atpg_vector_sequencer.sv
// Applies stored stimulus vectors to a combinational CUT, captures and
// compares each response after a settle delay, and compacts them in a MISR.
module atpg_vector_sequencer
   import atpg_pkg::*;
#(
   parameter  int unsigned      IN_W   = 41,
   parameter  int unsigned      OUT_W  = 32,
   parameter  int unsigned      DEPTH  = 16,
   parameter  int unsigned      SETTLE = 1,
   parameter  logic [OUT_W-1:0] POLY   = OUT_W'(MISR_POLY_DEFAULT),
   localparam int unsigned      AW     = $clog2(DEPTH),
   localparam int unsigned      CW     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_en,
   input  logic [AW-1:0]    ld_addr,
   input  logic [IN_W-1:0]  ld_stim,
   input  logic [OUT_W-1:0] ld_exp,
   input  logic [CW-1:0]    num_vec,
   input  logic             start,
   output logic [IN_W-1:0]  cut_in,
   input  logic [OUT_W-1:0] cut_out,
   output logic             busy,
   output logic             done,
   output logic             resp_valid,
   output logic [AW-1:0]    resp_idx,
   output logic [OUT_W-1:0] resp_data,
   output logic [CW-1:0]    mismatch_cnt,
   output logic             fail,
   output logic [AW-1:0]    first_fail_idx,
   output logic [OUT_W-1:0] signature
);

   localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t           state, state_nxt;
   logic [AW-1:0]    idx;
   logic [CW-1:0]    nvec;
   logic [CW-1:0]    nvec_clamp;
   logic [SW-1:0]    settle_cnt;
   logic [IN_W-1:0]  stim_c;
   logic [OUT_W-1:0] exp_c;
   logic             mem_we;
   logic             run_go;
   logic             last_vec;
   logic             busy_nxt;
   logic [OUT_W-1:0] sig_nxt;

   atpg_vec_mem #(
      .DEPTH (DEPTH),
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we),
      .waddr   (ld_addr),
      .wstim   (ld_stim),
      .wexp    (ld_exp),
      .raddr   (idx),
      .rstim_c (stim_c),
      .rexp_c  (exp_c)
   );

   assign nvec_clamp = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
   assign last_vec   = (CW'(idx) == (nvec - CW'(1)));
   assign sig_nxt    = OUT_W'(misr_step(MISR_MAX_W'(signature), MISR_MAX_W'(cut_out),
                                        MISR_MAX_W'(POLY), OUT_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next state plus memory-write and run-launch strobes.
   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      run_go    = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            mem_we = ld_en;
            if (start) begin
               run_go    = 1'b1;
               state_nxt = (nvec_clamp == '0) ? ST_DONE : ST_APPLY;
            end
         end
         ST_APPLY:   state_nxt = ST_SETTLE;
         ST_SETTLE:  if (settle_cnt == '0) state_nxt = ST_CAPTURE;
         ST_CAPTURE: state_nxt = last_vec ? ST_DONE : ST_APPLY;
         default:    state_nxt = ST_IDLE;
      endcase
      busy_nxt = (state_nxt == ST_APPLY) || (state_nxt == ST_SETTLE) ||
                 (state_nxt == ST_CAPTURE);
   end

   // Datapath: status flags track the next state so done lines up with the last response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cut_in         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         resp_valid     <= 1'b0;
         resp_idx       <= '0;
         resp_data      <= '0;
         mismatch_cnt   <= '0;
         fail           <= 1'b0;
         first_fail_idx <= '0;
         signature      <= '0;
         idx            <= '0;
         nvec           <= '0;
         settle_cnt     <= '0;
      end else begin
         resp_valid <= 1'b0;
         busy       <= busy_nxt;
         done       <= (state_nxt == ST_DONE);
         if (run_go) begin
            nvec           <= nvec_clamp;
            idx            <= '0;
            mismatch_cnt   <= '0;
            fail           <= 1'b0;
            first_fail_idx <= '0;
            signature      <= '0;
         end
         if (state == ST_APPLY) begin
            cut_in     <= stim_c;
            settle_cnt <= SW'(SETTLE - 1);
         end
         if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SW'(1);
         end
         if (state == ST_CAPTURE) begin
            resp_valid <= 1'b1;
            resp_idx   <= idx;
            resp_data  <= cut_out;
            signature  <= sig_nxt;
            if (cut_out != exp_c) begin
               mismatch_cnt <= mismatch_cnt + CW'(1);
               fail         <= 1'b1;
               if (!fail) first_fail_idx <= idx;
            end
            if (!last_vec) idx <= idx + AW'(1);
         end
      end
   end

endmodule
